// File: rtl/alu_pipe_n.sv
// Two-stage pipelined ALU (operand register -> result/flag register), WIDTH-bit datapath.
// Latency: input transfer at edge N presents the result after edge N+1; one op per cycle.
// Backpressure: a stalled output holds stage 2; in_ready drops only when both stages are full.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready             upstream handshake carrying A, B, OpCode
//   out_valid/out_ready           downstream handshake carrying Result and flags
//   Zero/Carry/Overflow/Neg/Err   result flags, registered alongside Result
module alu_pipe_n #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       OpCode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero_Flag,
    output logic             Carry_Flag,
    output logic             Overflow_Flag,
    output logic             Neg_Flag,
    output logic             Err_Flag
);

    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    // Stage 1: captured operation
    logic             s1_vld_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;

    // Stage 2: registered result and flags
    logic             out_vld_q;
    logic [WIDTH-1:0] res_q;
    logic             zero_q, carry_q, ovf_q, neg_q, err_q;

    // Next values for stage 2, computed from stage 1
    logic [WIDTH-1:0] res_d;
    logic             zero_d, carry_d, ovf_d, neg_d, err_d;

    logic             s2_adv;
    logic             in_xfer;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [SHW-1:0]   shamt_w;
    logic             slt_w;
    logic             sltu_w;

    // Stage 2 may load whenever it is empty or its content is leaving this cycle.
    assign s2_adv   = !out_vld_q || out_ready;
    assign in_ready = !s1_vld_q || s2_adv;
    assign in_xfer  = in_valid && in_ready;

    // Extra top bit gives carry out of ADD and borrow out of SUB.
    assign sum_w   = {1'b0, a_q} + {1'b0, b_q};
    assign diff_w  = {1'b0, a_q} - {1'b0, b_q};
    assign shamt_w = b_q[SHW-1:0];
    assign slt_w   = $signed(a_q) < $signed(b_q);
    assign sltu_w  = a_q < b_q;

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_d   = sum_w[MSB:0];
                carry_d = sum_w[WIDTH];
                ovf_d   = (a_q[MSB] == b_q[MSB]) && (sum_w[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                res_d   = diff_w[MSB:0];
                carry_d = diff_w[WIDTH];
                ovf_d   = (a_q[MSB] != b_q[MSB]) && (diff_w[MSB] != a_q[MSB]);
            end
            OP_AND:  res_d = a_q & b_q;
            OP_OR:   res_d = a_q | b_q;
            OP_XOR:  res_d = a_q ^ b_q;
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, slt_w};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, sltu_w};
            OP_SHL:  res_d = a_q << shamt_w;
            OP_SHR:  res_d = a_q >> shamt_w;
            OP_SRA:  res_d = $unsigned($signed(a_q) >>> shamt_w);
            default: err_d = 1'b1;
        endcase
        zero_d = (res_d == '0);
        neg_d  = res_d[MSB];
    end

    // Stage 1: load on transfer, otherwise empty out once stage 2 has taken the content.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
        end else if (in_xfer) begin
            s1_vld_q <= 1'b1;
            a_q      <= A;
            b_q      <= B;
            op_q     <= OpCode;
        end else if (s2_adv) begin
            s1_vld_q <= 1'b0;
        end
    end

    // Stage 2: held bit-stable while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            res_q     <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            neg_q     <= 1'b0;
            err_q     <= 1'b0;
        end else if (s2_adv) begin
            out_vld_q <= s1_vld_q;
            res_q     <= res_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            neg_q     <= neg_d;
            err_q     <= err_d;
        end
    end

    assign out_valid     = out_vld_q;
    assign Result        = res_q;
    assign Zero_Flag     = zero_q;
    assign Carry_Flag    = carry_q;
    assign Overflow_Flag = ovf_q;
    assign Neg_Flag      = neg_q;
    assign Err_Flag      = err_q;

endmodule

// File: tb/tb_alu_pipe_n.sv
// Bench for alu_pipe_n (WIDTH=8): directed steps followed by a randomized phase
// checked against an integer-arithmetic reference model and an in-order queue.
// Flags are compared as the vector {Zero, Carry, Overflow, Neg, Err}.
module tb_alu_pipe_n;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   OpCode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Result;
    logic         Zero_Flag, Carry_Flag, Overflow_Flag, Neg_Flag, Err_Flag;

    int checks = 0;
    int errors = 0;

    logic [12:0] exp_q[$];

    alu_pipe_n #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .A            (A),
        .B            (B),
        .OpCode       (OpCode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .Result       (Result),
        .Zero_Flag    (Zero_Flag),
        .Carry_Flag   (Carry_Flag),
        .Overflow_Flag(Overflow_Flag),
        .Neg_Flag     (Neg_Flag),
        .Err_Flag     (Err_Flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] flags();
        return {Zero_Flag, Carry_Flag, Overflow_Flag, Neg_Flag, Err_Flag};
    endfunction

    // Reference: plain integer arithmetic on the unsigned and signed readings of A and B.
    // Returns {Result[7:0], Zero, Carry, Overflow, Neg, Err}.
    function automatic logic [12:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
        int ua = int'(a);
        int ub = int'(b);
        int sa = (ua > 127) ? ua - 256 : ua;
        int sb = (ub > 127) ? ub - 256 : ub;
        int sh = ub % 8;
        int r  = 0;
        bit c  = 1'b0;
        bit v  = 1'b0;
        bit e  = 1'b0;
        logic [7:0] rb;
        case (op)
            4'd0: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            4'd1: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: r = (sa < sb) ? 1 : 0;
            4'd6: r = (ua < ub) ? 1 : 0;
            4'd7: r = ua * (2 ** sh);
            4'd8: r = ua / (2 ** sh);
            4'd9: r = sa >>> sh;
            default: begin r = 0; e = 1'b1; end
        endcase
        rb = r[7:0];
        return {rb, (rb == 8'd0), c, v, rb[7], e};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single op into an empty pipeline with out_ready=1: result appears two edges after the transfer.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_res,
                         input logic [4:0] exp_flg);
        in_valid = 1'b1; OpCode = op; A = a; B = b;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk({tag, "_valid_early"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_result"}, 32'(Result), 32'(exp_res));
        chk({tag, "_flags"}, 32'(flags()), 32'(exp_flg));
        step();
        chk({tag, "_bubble"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [12:0] m;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; OpCode = '0;

        // Reset state
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_result", 32'(Result), 32'd0);
        chk("rst_flags", 32'(flags()), 32'd0);
        rst_n = 1'b1;
        step();

        // Directed arithmetic, compare, shift, illegal
        do_op("add_ovf",  4'd0,  8'h7F, 8'h01, 8'h80, 5'b00110);
        do_op("sub_brw",  4'd1,  8'h00, 8'h01, 8'hFF, 5'b01010);
        do_op("add_wrap", 4'd0,  8'hFF, 8'h01, 8'h00, 5'b11000);
        do_op("slt",      4'd5,  8'h80, 8'h01, 8'h01, 5'b00000);
        do_op("sltu",     4'd6,  8'h80, 8'h01, 8'h00, 5'b10000);
        do_op("sra",      4'd9,  8'h80, 8'h0B, 8'hF0, 5'b00010);
        do_op("shr",      4'd8,  8'h80, 8'h03, 8'h10, 5'b00000);
        do_op("shl",      4'd7,  8'h81, 8'h09, 8'h02, 5'b00000);
        do_op("illegal",  4'd12, 8'h55, 8'h00, 8'h00, 5'b10001);
        do_op("after_il", 4'd2,  8'h0F, 8'hF3, 8'h03, 5'b00000);

        // Backpressure: fill both stages, third op held off
        out_ready = 1'b0;
        in_valid = 1'b1; OpCode = 4'd0; A = 8'd1; B = 8'd1;
        step();
        A = 8'd2; B = 8'd2;
        chk("bp_accept2", 32'(in_ready), 32'd1);
        step();
        A = 8'd3; B = 8'd3;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_hold", 32'(Result), 32'h02);
            A = 8'($urandom); B = 8'($urandom); OpCode = 4'($urandom);
            step();
            A = 8'd3; B = 8'd3; OpCode = 4'd0;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_first", 32'(Result), 32'h02);
        step();
        in_valid = 1'b0;
        chk("bp_second_vld", 32'(out_valid), 32'd1);
        chk("bp_second", 32'(Result), 32'h04);
        step();
        chk("bp_third_vld", 32'(out_valid), 32'd1);
        chk("bp_third", 32'(Result), 32'h06);
        step();
        chk("bp_no_dup", 32'(out_valid), 32'd0);

        // Reset while full: output must clear without a clock edge
        out_ready = 1'b0;
        in_valid = 1'b1; A = 8'd7; B = 8'd7; OpCode = 4'd0;
        step();
        A = 8'd8; B = 8'd8;
        step();
        in_valid = 1'b0;
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_stale", 32'(out_valid), 32'd0);
        end
        do_op("post_rst", 4'd0, 8'd5, 8'd5, 8'h0A, 5'b00000);

        // Randomized traffic against the reference model and an in-order queue
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            A = 8'($urandom); B = 8'($urandom); OpCode = 4'($urandom_range(0, 15));
            #1;
            chk("rnd_in_ready", 32'(in_ready),
                32'(!(exp_q.size() == 2 && !out_ready)));
            if (exp_q.size() == 0)
                chk("rnd_idle_valid", 32'(out_valid), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_out", 32'd1, 32'd0);
                end else begin
                    m = exp_q.pop_front();
                    chk("rnd_result", 32'(Result), 32'(m[12:5]));
                    chk("rnd_flags", 32'(flags()), 32'(m[4:0]));
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(A, B, OpCode));
            step();
        end

        // Drain within a bounded number of cycles
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("drain_unexpected_out", 32'd1, 32'd0);
                end else begin
                    m = exp_q.pop_front();
                    chk("drain_result", 32'(Result), 32'(m[12:5]));
                    chk("drain_flags", 32'(flags()), 32'(m[4:0]));
                end
            end
            step();
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
